// File: rtl/ifb_pkg.sv
// Shared types and constants for the instruction fetch pair buffer.
package ifb_pkg;
    localparam int IFB_ADDR_W  = 8;
    localparam int IFB_INSTR_W = 16;

    localparam logic [2:0] HALT_OPCODE = 3'b111;

    typedef struct packed {
        logic [IFB_INSTR_W-1:0] instr;
        logic [IFB_ADDR_W-1:0]  pc;
    } fetch_entry_t;

    typedef struct packed {
        logic [IFB_ADDR_W-1:0] pc;
        logic                  epoch;
    } inflight_tag_t;

    function automatic logic is_halt(input logic [IFB_INSTR_W-1:0] word);
        return word[IFB_INSTR_W-1 -: 3] == HALT_OPCODE;
    endfunction
endpackage

// File: rtl/ifb_dual_pop_fifo.sv
// Circular queue of fetch entries: single push, pop of 0/1/2, flush, exposes head and head+1.
module ifb_dual_pop_fifo
    import ifb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic [1:0]               pop_n,
    output fetch_entry_t             head_entry,
    output fetch_entry_t             next_entry,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    // Tail is derived from the pre-pop count, so a same-cycle pop never moves it.
    assign tail       = head + count[PTR_W-1:0];
    assign head_entry = mem[head];
    assign next_entry = mem[head + PTR_W'(1)];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(pop_n);
            count <= count + CNT_W'(push) - CNT_W'(pop_n);
        end
    end
endmodule

// File: rtl/ifetch_pair_buffer.sv
// Fetches one word per cycle into a small queue and presents the two oldest as an issue pair.
// Optional HALT detection is enabled by defining IFB_HALT_DETECT_EN.
module ifetch_pair_buffer
    import ifb_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = IFB_ADDR_W,
    parameter int INSTR_W = IFB_INSTR_W
) (
    input  logic               clk,
    input  logic               reset,
    output logic               mem_rd,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               fetch_next,
    output logic [INSTR_W-1:0] p0_IR,
    output logic [INSTR_W-1:0] p1_IR,
    output logic               p0_valid,
    output logic               p1_valid,
    output logic [ADDR_W-1:0]  p0_pc,
    output logic               halted
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] fetch_pc;
    logic              epoch;
    logic              inflight_vld;
    inflight_tag_t     inflight_tag;

    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  post_pop;
    logic [1:0]        pop_n;
    logic              push;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;
    fetch_entry_t      next_entry;

    assign p0_valid = count >= CNT_W'(1);
    assign p1_valid = count >= CNT_W'(2);

    assign pop_n    = (fetch_next && !redirect) ? ({1'b0, p0_valid} + {1'b0, p1_valid}) : 2'd0;
    assign post_pop = count - CNT_W'(pop_n);

    // Reserving a slot for the in-flight word is what keeps the queue from overflowing.
    assign mem_rd   = !reset && !halted && !redirect &&
                      ((post_pop + CNT_W'(inflight_vld)) < CNT_W'(DEPTH));
    assign mem_addr = mem_rd ? fetch_pc : '0;

    assign push       = inflight_vld && (inflight_tag.epoch == epoch) && !redirect && !halted;
    assign push_entry = '{instr: mem_rdata, pc: inflight_tag.pc};

    assign p0_IR = p0_valid ? head_entry.instr : '0;
    assign p1_IR = p1_valid ? next_entry.instr : '0;
    assign p0_pc = p0_valid ? head_entry.pc    : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc     <= '0;
            epoch        <= 1'b0;
            inflight_vld <= 1'b0;
            inflight_tag <= '0;
        end else begin
            inflight_vld <= mem_rd;
            inflight_tag <= '{pc: fetch_pc, epoch: epoch};
            if (redirect) begin
                fetch_pc <= redirect_pc;
                epoch    <= ~epoch;
            end else if (mem_rd) begin
                fetch_pc <= fetch_pc + ADDR_W'(1);
            end
        end
    end

`ifdef IFB_HALT_DETECT_EN
    // A word returning after the HALT sees halted=1 and is dropped by the push gate.
    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            halted <= 1'b0;
        end else if (push && is_halt(mem_rdata)) begin
            halted <= 1'b1;
        end
    end
`else
    assign halted = 1'b0;
`endif

    ifb_dual_pop_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect),
        .push       (push),
        .push_entry (push_entry),
        .pop_n      (pop_n),
        .head_entry (head_entry),
        .next_entry (next_entry),
        .count      (count)
    );
endmodule

// File: tb/tb_ifetch_pair_buffer.sv
// Directed bench for ifetch_pair_buffer with a 1-cycle-latency instruction memory model.
module tb_ifetch_pair_buffer;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic [15:0] mem_rdata = '0;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        fetch_next;
    logic [15:0] p0_IR, p1_IR;
    logic        p0_valid, p1_valid;
    logic [7:0]  p0_pc;
    logic        halted;

    logic [15:0] imem [256];
    int n_cmp = 0;
    int n_err = 0;

    ifetch_pair_buffer dut (
        .clk         (clk),
        .reset       (reset),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .fetch_next  (fetch_next),
        .p0_IR       (p0_IR),
        .p1_IR       (p1_IR),
        .p0_valid    (p0_valid),
        .p1_valid    (p1_valid),
        .p0_pc       (p0_pc),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= imem[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start();
        reset = 1'b1;
        redirect = 1'b0;
        fetch_next = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        fetch_next = 1'b0;
        for (int i = 0; i < 256; i++) imem[i] = 16'hA000 + 16'(i);

        // reset held 3 cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_rd", 32'(mem_rd), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_p0_valid", 32'(p0_valid), 0);
        chk("rst_p1_valid", 32'(p1_valid), 0);
        chk("rst_p0_IR", 32'(p0_IR), 0);
        chk("rst_p1_IR", 32'(p1_IR), 0);
        chk("rst_p0_pc", 32'(p0_pc), 0);
        chk("rst_halted", 32'(halted), 0);
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("first_rd", 32'(mem_rd), 1);
        chk("first_addr", 32'(mem_addr), 0);

        // fill with no consumption, then one pair pop
        start();
        for (int c = 0; c < 8; c++) begin
            fetch_next = (c == 6);
            @(negedge clk);
            case (c)
                1: begin chk("fill_c1_addr", 32'(mem_addr), 1); chk("fill_c1_v0", 32'(p0_valid), 0); end
                2: begin chk("fill_c2_v0", 32'(p0_valid), 1); chk("fill_c2_ir0", 32'(p0_IR), 32'hA000);
                         chk("fill_c2_v1", 32'(p1_valid), 0); end
                3: begin chk("fill_c3_v1", 32'(p1_valid), 1); chk("fill_c3_ir1", 32'(p1_IR), 32'hA001);
                         chk("fill_c3_rd", 32'(mem_rd), 1); chk("fill_c3_addr", 32'(mem_addr), 3); end
                4: chk("fill_c4_rd", 32'(mem_rd), 0);
                5: begin chk("fill_c5_rd", 32'(mem_rd), 0); chk("fill_c5_pc", 32'(p0_pc), 0); end
                6: begin chk("fill_c6_rd", 32'(mem_rd), 1); chk("fill_c6_addr", 32'(mem_addr), 4); end
                7: begin chk("fill_c7_ir0", 32'(p0_IR), 32'hA002); chk("fill_c7_ir1", 32'(p1_IR), 32'hA003);
                         chk("fill_c7_pc", 32'(p0_pc), 2); end
                default: ;
            endcase
            cyc();
        end
        fetch_next = 1'b0;

        // streaming consumption: one word per cycle, single issue
        start();
        fetch_next = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c < 2) begin
                chk("strm_v0_early", 32'(p0_valid), 0);
            end else begin
                chk("strm_v0", 32'(p0_valid), 1);
                chk("strm_pc", 32'(p0_pc), 32'(c - 2));
                chk("strm_ir", 32'(p0_IR), 32'hA000 + 32'(c - 2));
                chk("strm_v1", 32'(p1_valid), 0);
            end
            cyc();
        end

        // redirect to 0x40 while 0x03 is in flight
        start();
        fetch_next = 1'b1;
        redirect_pc = 8'h40;
        for (int c = 0; c < 9; c++) begin
            redirect = (c == 4);
            @(negedge clk);
            case (c)
                4: begin chk("redir_c4_rd", 32'(mem_rd), 0); chk("redir_c4_pc", 32'(p0_pc), 2); end
                5: begin chk("redir_c5_v0", 32'(p0_valid), 0); chk("redir_c5_rd", 32'(mem_rd), 1);
                         chk("redir_c5_addr", 32'(mem_addr), 32'h40); end
                6: begin chk("redir_c6_v0", 32'(p0_valid), 0); chk("redir_c6_addr", 32'(mem_addr), 32'h41); end
                7: begin chk("redir_c7_pc", 32'(p0_pc), 32'h40); chk("redir_c7_ir", 32'(p0_IR), 32'hA040); end
                8: chk("redir_c8_pc", 32'(p0_pc), 32'h41);
                default: ;
            endcase
            cyc();
        end
        redirect = 1'b0;

        // address wrap through 0xFF
        start();
        fetch_next = 1'b1;
        redirect_pc = 8'hFE;
        for (int c = 0; c < 7; c++) begin
            redirect = (c == 0);
            @(negedge clk);
            case (c)
                1: chk("wrap_addr", 32'(mem_addr), 32'hFE);
                3: begin chk("wrap_pc_fe", 32'(p0_pc), 32'hFE); chk("wrap_ir_fe", 32'(p0_IR), 32'hA0FE); end
                4: begin chk("wrap_pc_ff", 32'(p0_pc), 32'hFF); chk("wrap_ir_ff", 32'(p0_IR), 32'hA0FF); end
                5: begin chk("wrap_pc_00", 32'(p0_pc), 32'h00); chk("wrap_ir_00", 32'(p0_IR), 32'hA000); end
                6: chk("wrap_pc_01", 32'(p0_pc), 32'h01);
                default: ;
            endcase
            cyc();
        end
        redirect = 1'b0;

        // HALT word at 0x02
        imem[2] = 16'hE000;
        start();
        redirect_pc = 8'h10;
        for (int c = 0; c < 28; c++) begin
            fetch_next = (c == 24);
            redirect = (c == 26);
            @(negedge clk);
            if (c >= 4 && c < 24) chk("halt_no_rd", 32'(mem_rd), 0);
            case (c)
                3: chk("halt_c3_h", 32'(halted), 0);
                5: begin chk("halt_c5_pc", 32'(p0_pc), 0); chk("halt_c5_ir1", 32'(p1_IR), 32'hA001); end
`ifdef IFB_HALT_DETECT_EN
                4: chk("halt_c4_h", 32'(halted), 1);
                25: begin chk("halt_c25_ir0", 32'(p0_IR), 32'hE000); chk("halt_c25_pc", 32'(p0_pc), 2);
                          chk("halt_c25_v1", 32'(p1_valid), 0); chk("halt_c25_h", 32'(halted), 1); end
`else
                4: chk("nohalt_c4_h", 32'(halted), 0);
                25: begin chk("nohalt_c25_ir0", 32'(p0_IR), 32'hE000); chk("nohalt_c25_ir1", 32'(p1_IR), 32'hA003);
                          chk("nohalt_c25_h", 32'(halted), 0); end
`endif
                27: begin chk("halt_c27_h", 32'(halted), 0); chk("halt_c27_rd", 32'(mem_rd), 1);
                          chk("halt_c27_addr", 32'(mem_addr), 32'h10); chk("halt_c27_v0", 32'(p0_valid), 0); end
                default: ;
            endcase
            cyc();
        end
        redirect = 1'b0;
        fetch_next = 1'b0;
        imem[2] = 16'hA002;

        // reset mid-operation discards the in-flight read
        start();
        for (int c = 0; c < 6; c++) begin
            reset = (c == 2);
            @(negedge clk);
            case (c)
                2: chk("mrst_rd", 32'(mem_rd), 0);
                3: begin chk("mrst_v0", 32'(p0_valid), 0); chk("mrst_addr", 32'(mem_addr), 0); end
                4: chk("mrst_v0_b", 32'(p0_valid), 0);
                5: begin chk("mrst_pc", 32'(p0_pc), 0); chk("mrst_ir", 32'(p0_IR), 32'hA000);
                         chk("mrst_v1", 32'(p1_valid), 0); end
                default: ;
            endcase
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
